blk_shift_buf: RTL
==================

# blk_shift_buf

Parametrised shift buffer for block-luminance samples in the backlight dimming datapath. It collects DEPTH consecutive DW-bit samples, presents them as a flat parallel bus in either linear or two-row interleaved slot order, and flags when a complete window has been captured. It sits between the per-block luminance extractor and the LED-zone duty calculator. Optional window statistics (running sum and maximum) feed the dimming decision directly.

## Interface
- DW, 16, sample width in bits
- DEPTH, 10, number of slots; ≥2; must be even when INTERLEAVE=1
- INTERLEAVE, 1, 0 = linear slot order, 1 = two-row interleaved order
- SW, DW+$clog2(DEPTH+1), width of the statistics sum
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- EN_count  in  1  sample strobe; Din is accepted on every posedge with EN_count=1
- clear  in  1  synchronous flush; priority over EN_count
- Din  in  DW  input sample
- Qout  out  DW*DEPTH  slot s occupies bits [s*DW +: DW]
- fill  out  $clog2(DEPTH+1)  accepted samples in the current run, saturating at DEPTH
- CS_set  out  1  window-complete flag
- win_sum  out  SW  sum of filled slots (stats build only)
- win_max  out  DW  maximum of filled slots (stats build only)

## Operation
- Chain position k (0 = newest) maps to a slot:
  - INTERLEAVE=0: slot = k.
  - INTERLEAVE=1: slot = k/2 + (k%2)*(DEPTH/2). For DEPTH=10, chain positions 0..9 map to slots 0,5,1,6,2,7,3,8,4,9.
- Accept (EN_count=1, clear=0):
  - Chain position 0 ← Din.
  - Position k ← position k-1.
  - The oldest sample is discarded.
  - fill ← min(fill+1, DEPTH).
- Run break (EN_count=0, clear=0):
  - Slot data holds.
  - fill ← 0 and CS_set ← 0.
  - The next run refills from fill=0 over the retained data.
- Clear: all slots, fill, CS_set and the statistics go to 0. A Din presented in the same cycle is dropped.
- CS_set ← 1 on the accepted edge that brings fill to DEPTH. It stays 1 while EN_count stays high. It drops on the first cycle EN_count is low, or on clear.
- fill saturates at DEPTH and never wraps.
- Reset: Qout=0, fill=0, CS_set=0, win_sum=0, win_max=0.
- Reset asserted mid-run: everything clears asynchronously. The first accept after deassertion behaves as fill=0.

## Timing
- Qout and fill update on the accepting edge. The sample is visible on Qout the cycle after Din is presented.
- CS_set: combined with the accepting edge, a run produces CS_set=1 exactly DEPTH accepted edges after it starts.
- win_sum and win_max: registered, one cycle after the accepting edge. Each reflects the slot contents produced by that edge.
- win_sum arithmetic:
  - Updated incrementally: win_sum ← win_sum + Din − evicted.
  - evicted is the oldest chain value when fill==DEPTH before the edge, else 0.
  - Unsigned, no overflow by construction of SW.
- win_max:
  - Unsigned maximum over chain positions < fill, computed from the updated chain.
  - Entries beyond fill are ignored, so retained stale data from a previous run is excluded.
- Run break: win_sum and win_max go to 0 one cycle after the EN_count-low edge, tracking fill=0. Slot data is untouched.

## Configuration
- BLK_SHIFT_STATS_EN defined: win_sum and win_max logic is built exactly as above.
- BLK_SHIFT_STATS_EN undefined:
  - Both ports remain and are tied to constant 0.
  - No statistics registers or adders are synthesised.
  - All other behaviour is identical.

## Test plan
All scenarios use DW=16, DEPTH=10, INTERLEAVE=1 and BLK_SHIFT_STATS_EN defined unless noted.

- Fill and flag: reset, then EN_count=1 for 10 cycles with Din=1..10.
  - CS_set rises on the 10th edge.
  - Slots 0..9 read 10,8,6,4,2,9,7,5,3,1.
  - One cycle later, win_sum=55 and win_max=10.
- Saturation and eviction: continue with Din=11 and Din=12.
  - fill stays 10 and CS_set stays 1.
  - win_sum reaches 65, then 75. win_max reaches 11, then 12.
- Run break: drop EN_count for 1 cycle, then resume with Din=3.
  - CS_set=0 and fill=0 on the break; slot data is retained.
  - After resume, fill=1, win_sum=3 and win_max=3, even though stale slots hold larger values.
- Clear priority: assert clear and EN_count together with Din=0xFFFF.
  - All slots=0, fill=0, CS_set=0; the sample is dropped.
- Async reset mid-run: assert reset between clock edges at fill=6.
  - Outputs go to 0 before the next edge.
  - After release, 10 accepts are needed for CS_set.
- Linear build: rerun the fill scenario with INTERLEAVE=0 and BLK_SHIFT_STATS_EN undefined.
  - Slots 0..9 read 10..1.
  - win_sum and win_max stay 0 throughout.

Source files
------------

// File: rtl/blk_shift_buf.sv
// -----------------------------------------------------------------------------
// blk_shift_buf
// Shift buffer for block-luminance samples in the backlight dimming datapath.
// Collects DEPTH consecutive DW-bit samples, presents them as a flat parallel
// bus in linear or two-row interleaved slot order, and flags a complete window.
//
// Optional feature macro: BLK_SHIFT_STATS_EN
//   defined   -> registered window statistics (running sum and maximum)
//   undefined -> win_sum / win_max tied to 0, no statistics logic built
//
// Ports
//   clock     : single clock, all state updates on posedge
//   reset     : asynchronous active-high, clears all state
//   EN_count  : sample strobe, Din accepted on every posedge with EN_count=1
//   clear     : synchronous flush, priority over EN_count
//   Din       : input sample
//   Qout      : DEPTH slots, slot s at bits [s*DW +: DW]
//   fill      : accepted samples in the current run, saturating at DEPTH
//   CS_set    : window-complete flag
//   win_sum   : sum of filled slots (statistics build only)
//   win_max   : maximum of filled slots (statistics build only)
// -----------------------------------------------------------------------------
module blk_shift_buf #(
   parameter int DW         = 16,
   parameter int DEPTH      = 10,
   parameter int INTERLEAVE = 1,
   parameter int SW         = DW + $clog2(DEPTH + 1)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       EN_count,
   input  logic                       clear,
   input  logic [DW-1:0]              Din,
   output logic [DW*DEPTH-1:0]        Qout,
   output logic [$clog2(DEPTH+1)-1:0] fill,
   output logic                       CS_set,
   output logic [SW-1:0]              win_sum,
   output logic [DW-1:0]              win_max
);

   localparam int             FW   = $clog2(DEPTH + 1);
   localparam logic [FW-1:0]  FULL = FW'(DEPTH);

   // Saturating run-length increment: fill never wraps past DEPTH.
   function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] f);
      return (f == FULL) ? f : f + FW'(1);
   endfunction

   logic [DW-1:0] chain_p0 [DEPTH];
   logic [FW-1:0] fill_p0;
   logic          cs_p0;
   logic          vld_p0;

   assign vld_p0 = EN_count & ~clear;

   // ---- stage p0: sample chain, run length, window flag ----
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) chain_p0[k] <= '0;
         fill_p0 <= '0;
         cs_p0   <= 1'b0;
      end else if (clear) begin
         for (int k = 0; k < DEPTH; k++) chain_p0[k] <= '0;
         fill_p0 <= '0;
         cs_p0   <= 1'b0;
      end else if (vld_p0) begin
         chain_p0[0] <= Din;
         for (int k = 1; k < DEPTH; k++) chain_p0[k] <= chain_p0[k-1];
         fill_p0 <= sat_inc(fill_p0);
         cs_p0   <= (sat_inc(fill_p0) == FULL);
      end else begin
         // Run break: data retained, the next run counts again from zero.
         fill_p0 <= '0;
         cs_p0   <= 1'b0;
      end
   end

   // Chain position k to output slot. Interleaved order puts even positions
   // in the lower half-row and odd positions in the upper half-row.
   for (genvar k = 0; k < DEPTH; k++) begin : g_slot
      localparam int SLOT = (INTERLEAVE != 0) ? (k / 2 + (k % 2) * (DEPTH / 2)) : k;
      assign Qout[SLOT*DW +: DW] = chain_p0[k];
   end

   assign fill   = fill_p0;
   assign CS_set = cs_p0;

`ifdef BLK_SHIFT_STATS_EN
   function automatic logic [DW-1:0] umax(input logic [DW-1:0] a, input logic [DW-1:0] b);
      return (a > b) ? a : b;
   endfunction

   logic [SW-1:0] sum_p0;
   logic [SW-1:0] win_sum_p1;
   logic [DW-1:0] win_max_p1;
   logic [DW-1:0] evict;
   logic [DW-1:0] max_c;

   // Only a full window pushes a counted sample out of the sum.
   assign evict = (fill_p0 == FULL) ? chain_p0[DEPTH-1] : '0;

   // Maximum over the current run only; stale retained slots are skipped.
   always_comb begin
      max_c = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (FW'(k) < fill_p0) max_c = umax(max_c, chain_p0[k]);
      end
   end

   // ---- stage p0 running sum / stage p1 registered statistics ----
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sum_p0     <= '0;
         win_sum_p1 <= '0;
         win_max_p1 <= '0;
      end else if (clear) begin
         sum_p0     <= '0;
         win_sum_p1 <= '0;
         win_max_p1 <= '0;
      end else begin
         win_sum_p1 <= sum_p0;
         win_max_p1 <= max_c;
         if (vld_p0) sum_p0 <= sum_p0 + SW'(Din) - SW'(evict);
         else        sum_p0 <= '0;
      end
   end

   assign win_sum = win_sum_p1;
   assign win_max = win_max_p1;
`else
   assign win_sum = '0;
   assign win_max = '0;
`endif

endmodule
